// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with pixel-source
// latency compensation, integer pixel repetition and sync polarity.
//
// Ports:
//   clk_25_175  pixel clock
//   reset       asynchronous active-high reset
//   pix_en      clock enable; all state advances only when high
//   hcoord      requested pixel column (scaled), stage 0
//   vcoord      requested pixel row (scaled), stage 0
//   coord_valid hcoord/vcoord lie in the active area
//   line_start  strobe at h=0 of every line (coordinate side)
//   frame_start strobe at h=0, v=0 (coordinate side)
//   pixstream   pixel from source, {B,G,R} with R in the LSBs
//   h_sync      horizontal sync, registered
//   v_sync      vertical sync, registered
//   de          display enable, aligned with r/g/b
//   r, g, b     colour outputs, zero during blanking
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int COLOR_BITS  = 4,
  parameter int PIX_LATENCY = 1,
  parameter int SCALE       = 1,
  parameter int COORD_W     = 10
) (
  input  logic                    clk_25_175,
  input  logic                    reset,
  input  logic                    pix_en,
  output logic [COORD_W-1:0]      hcoord,
  output logic [COORD_W-1:0]      vcoord,
  output logic                    coord_valid,
  output logic                    line_start,
  output logic                    frame_start,
  input  logic [3*COLOR_BITS-1:0] pixstream,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    de,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOT = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int CNT_W   = $clog2(MAX_TOT);

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  // Sync state of raster position (0,0), used as the reset image
  // of the stage-0 registers.
  localparam logic HS_AT0 = (HS_BEG == 0) && (H_SYNC > 0);
  localparam logic VS_AT0 = (VS_BEG == 0) && (V_SYNC > 0);

  // Raster counters and their next values
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;

  // Repetition sub-counters and scaled coordinates
  logic [SUB_W-1:0]   h_sub;
  logic [SUB_W-1:0]   v_sub;
  logic [SUB_W-1:0]   h_sub_nxt;
  logic [SUB_W-1:0]   v_sub_nxt;
  logic [COORD_W-1:0] hcoord_nxt;
  logic [COORD_W-1:0] vcoord_nxt;

  // Stage-0 tuple for the sync/de pipeline
  logic hs0;
  logic vs0;
  logic act_nxt;
  logic hs_nxt;
  logic vs_nxt;

  // Tuple after the latency-compensation delay: {active, hs, vs}
  logic [2:0] tap;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + CNT_W'(1);
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  // hcoord tracks h_cnt/SCALE by counting SCALE pixels per step;
  // beyond the active area it simply stops advancing.
  always_comb begin
    h_sub_nxt  = h_sub;
    hcoord_nxt = hcoord;
    if (h_nxt == '0) begin
      h_sub_nxt  = '0;
      hcoord_nxt = '0;
    end else if (int'(h_nxt) < H_ACTIVE) begin
      if (h_sub == SUB_LAST) begin
        h_sub_nxt  = '0;
        hcoord_nxt = hcoord + COORD_W'(1);
      end else begin
        h_sub_nxt = h_sub + SUB_W'(1);
      end
    end
  end

  // vcoord uses the same scheme, stepping once per line.
  always_comb begin
    v_sub_nxt  = v_sub;
    vcoord_nxt = vcoord;
    if (h_wrap) begin
      if (v_nxt == '0) begin
        v_sub_nxt  = '0;
        vcoord_nxt = '0;
      end else if (int'(v_nxt) < V_ACTIVE) begin
        if (v_sub == SUB_LAST) begin
          v_sub_nxt  = '0;
          vcoord_nxt = vcoord + COORD_W'(1);
        end else begin
          v_sub_nxt = v_sub + SUB_W'(1);
        end
      end
    end
  end

  always_comb begin
    act_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    hs_nxt  = (int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END);
    vs_nxt  = (int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END);
  end

  // Stage 0: counters plus everything derived from them, all
  // describing the same raster position.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_sub       <= '0;
      v_sub       <= '0;
      hcoord      <= '0;
      vcoord      <= '0;
      coord_valid <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      hs0         <= HS_AT0;
      vs0         <= VS_AT0;
    end else if (pix_en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      h_sub       <= h_sub_nxt;
      v_sub       <= v_sub_nxt;
      hcoord      <= hcoord_nxt;
      vcoord      <= vcoord_nxt;
      coord_valid <= act_nxt;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      hs0         <= hs_nxt;
      vs0         <= vs_nxt;
    end
  end

  // Delay matching the pixel source latency so sync/de line up
  // with the pixel that belongs to the same coordinate.
  if (PIX_LATENCY > 0) begin : g_dly
    logic [2:0] dly [PIX_LATENCY];

    always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PIX_LATENCY; i++) begin
          dly[i] <= 3'b000;
        end
      end else if (pix_en) begin
        dly[0] <= {coord_valid, hs0, vs0};
        for (int i = 1; i < PIX_LATENCY; i++) begin
          dly[i] <= dly[i-1];
        end
      end
    end

    assign tap = dly[PIX_LATENCY-1];
  end else begin : g_nodly
    assign tap = {coord_valid, hs0, vs0};
  end

  // Output register: pixel fields are gated by the delayed active
  // bit so blanking always shows black.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      de     <= 1'b0;
      r      <= '0;
      g      <= '0;
      b      <= '0;
      h_sync <= ~HS_ON;
      v_sync <= ~VS_ON;
    end else if (pix_en) begin
      de     <= tap[2];
      r      <= pixstream[COLOR_BITS-1:0] & {COLOR_BITS{tap[2]}};
      g      <= pixstream[2*COLOR_BITS-1:COLOR_BITS]
                & {COLOR_BITS{tap[2]}};
      b      <= pixstream[3*COLOR_BITS-1:2*COLOR_BITS]
                & {COLOR_BITS{tap[2]}};
      h_sync <= tap[1] ? HS_ON : ~HS_ON;
      v_sync <= tap[0] ? VS_ON : ~VS_ON;
    end
  end

endmodule
